// File: rtl/ysyx_bus_arb.sv
// ysyx_bus_arb: IFU/LSU arbiter onto a single AXI4-Lite-style memory port, one transaction at a time.
// Build option: define YSYX_ARB_RR_EN for round-robin arbitration (otherwise fixed priority via LSU_PRIO).
module ysyx_bus_arb #(
    parameter int unsigned BIT_W    = 32,
    parameter bit          LSU_PRIO = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ifu_avalid,
    input  logic [BIT_W-1:0]     i_ifu_addr,
    output logic [BIT_W-1:0]     o_ifu_rdata,
    output logic                 o_ifu_rvalid,
    input  logic                 i_lsu_avalid,
    input  logic                 i_lsu_ren,
    input  logic                 i_lsu_wen,
    input  logic [BIT_W-1:0]     i_lsu_addr,
    input  logic [BIT_W-1:0]     i_lsu_wdata,
    input  logic [BIT_W/8-1:0]   i_lsu_wstrb,
    output logic [BIT_W-1:0]     o_lsu_rdata,
    output logic                 o_lsu_rvalid,
    output logic                 o_lsu_wready,
    output logic                 o_mem_arvalid,
    output logic [BIT_W-1:0]     o_mem_araddr,
    input  logic                 i_mem_arready,
    input  logic                 i_mem_rvalid,
    input  logic [BIT_W-1:0]     i_mem_rdata,
    input  logic [1:0]           i_mem_rresp,
    output logic                 o_mem_rready,
    output logic                 o_mem_awvalid,
    output logic [BIT_W-1:0]     o_mem_awaddr,
    input  logic                 i_mem_awready,
    output logic                 o_mem_wvalid,
    output logic [BIT_W-1:0]     o_mem_wdata,
    output logic [BIT_W/8-1:0]   o_mem_wstrb,
    input  logic                 i_mem_wready,
    input  logic                 i_mem_bvalid,
    input  logic [1:0]           i_mem_bresp,
    output logic                 o_mem_bready,
    output logic                 o_bus_err
);
    localparam int unsigned STRB_W = BIT_W / 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ADDR = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR_ADDR = 3'd3;
    localparam logic [2:0] S_WR_RESP = 3'd4;

    logic [2:0]        r_state, w_state_nxt;
    logic              r_owner, w_owner_nxt;
    logic [BIT_W-1:0]  r_addr, w_addr_nxt;
    logic [BIT_W-1:0]  r_wdata, w_wdata_nxt;
    logic [STRB_W-1:0] r_wstrb, w_wstrb_nxt;
    logic              r_arvalid, w_arvalid_nxt;
    logic              r_rready, w_rready_nxt;
    logic              r_awvalid, w_awvalid_nxt;
    logic              r_wvalid, w_wvalid_nxt;
    logic              r_bready, w_bready_nxt;
    logic              r_aw_done, w_aw_done_nxt;
    logic              r_w_done, w_w_done_nxt;
    logic [BIT_W-1:0]  r_ifu_rdata, w_ifu_rdata_nxt;
    logic [BIT_W-1:0]  r_lsu_rdata, w_lsu_rdata_nxt;
    logic              r_ifu_rvalid, w_ifu_rvalid_nxt;
    logic              r_lsu_rvalid, w_lsu_rvalid_nxt;
    logic              r_lsu_wready, w_lsu_wready_nxt;
    logic              r_bus_err, w_bus_err_nxt;
    logic              w_grant_lsu;
    logic              w_any_req;
    logic              w_resp_busy;
    logic              w_aw_fin;
    logic              w_w_fin;
    logic              w_unused;

    // Read vs write is decided by ren alone; wen only documents intent.
    assign w_unused    = i_lsu_wen;
    assign w_any_req   = i_ifu_avalid | i_lsu_avalid;
    // Masters still hold avalid while their pulse is visible, so no grant in that cycle.
    assign w_resp_busy = r_ifu_rvalid | r_lsu_rvalid | r_lsu_wready;

`ifdef YSYX_ARB_RR_EN
    logic r_rr_ptr, w_rr_ptr_nxt;
    assign w_grant_lsu = i_lsu_avalid & (~i_ifu_avalid | r_rr_ptr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rr_ptr <= 1'b0;
        else          r_rr_ptr <= w_rr_ptr_nxt;
    end
`else
    assign w_grant_lsu = i_lsu_avalid & (~i_ifu_avalid | LSU_PRIO);
`endif

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_wstrb_nxt      = r_wstrb;
        w_arvalid_nxt    = r_arvalid;
        w_rready_nxt     = r_rready;
        w_awvalid_nxt    = r_awvalid;
        w_wvalid_nxt     = r_wvalid;
        w_bready_nxt     = r_bready;
        w_aw_done_nxt    = r_aw_done;
        w_w_done_nxt     = r_w_done;
        w_ifu_rdata_nxt  = r_ifu_rdata;
        w_lsu_rdata_nxt  = r_lsu_rdata;
        w_ifu_rvalid_nxt = 1'b0;
        w_lsu_rvalid_nxt = 1'b0;
        w_lsu_wready_nxt = 1'b0;
        w_bus_err_nxt    = 1'b0;
`ifdef YSYX_ARB_RR_EN
        w_rr_ptr_nxt     = r_rr_ptr;
`endif
        w_aw_fin = r_aw_done | (r_awvalid & i_mem_awready);
        w_w_fin  = r_w_done  | (r_wvalid  & i_mem_wready);

        case (r_state)
            S_IDLE: begin
                if (w_any_req && !w_resp_busy) begin
                    w_owner_nxt = w_grant_lsu;
                    w_addr_nxt  = w_grant_lsu ? i_lsu_addr : i_ifu_addr;
                    w_wdata_nxt = i_lsu_wdata;
                    w_wstrb_nxt = i_lsu_wstrb;
`ifdef YSYX_ARB_RR_EN
                    w_rr_ptr_nxt = ~w_grant_lsu;
`endif
                    if (w_grant_lsu && !i_lsu_ren) begin
                        w_state_nxt   = S_WR_ADDR;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_aw_done_nxt = 1'b0;
                        w_w_done_nxt  = 1'b0;
                    end else begin
                        w_state_nxt   = S_RD_ADDR;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            S_RD_ADDR: begin
                if (i_mem_arready) begin
                    w_state_nxt   = S_RD_DATA;
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (i_mem_rvalid) begin
                    w_state_nxt   = S_IDLE;
                    w_rready_nxt  = 1'b0;
                    w_bus_err_nxt = |i_mem_rresp;
                    if (r_owner) begin
                        w_lsu_rdata_nxt  = i_mem_rdata;
                        w_lsu_rvalid_nxt = 1'b1;
                    end else begin
                        w_ifu_rdata_nxt  = i_mem_rdata;
                        w_ifu_rvalid_nxt = 1'b1;
                    end
                end
            end
            S_WR_ADDR: begin
                // Address and data channels retire independently; sticky flags remember each.
                if (r_awvalid && i_mem_awready) begin
                    w_awvalid_nxt = 1'b0;
                    w_aw_done_nxt = 1'b1;
                end
                if (r_wvalid && i_mem_wready) begin
                    w_wvalid_nxt = 1'b0;
                    w_w_done_nxt = 1'b1;
                end
                if (w_aw_fin && w_w_fin) begin
                    w_state_nxt  = S_WR_RESP;
                    w_bready_nxt = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (i_mem_bvalid) begin
                    w_state_nxt      = S_IDLE;
                    w_bready_nxt     = 1'b0;
                    w_lsu_wready_nxt = 1'b1;
                    w_bus_err_nxt    = |i_mem_bresp;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_ifu_rdata  <= '0;
            r_lsu_rdata  <= '0;
            r_ifu_rvalid <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            r_lsu_wready <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_wstrb      <= w_wstrb_nxt;
            r_arvalid    <= w_arvalid_nxt;
            r_rready     <= w_rready_nxt;
            r_awvalid    <= w_awvalid_nxt;
            r_wvalid     <= w_wvalid_nxt;
            r_bready     <= w_bready_nxt;
            r_aw_done    <= w_aw_done_nxt;
            r_w_done     <= w_w_done_nxt;
            r_ifu_rdata  <= w_ifu_rdata_nxt;
            r_lsu_rdata  <= w_lsu_rdata_nxt;
            r_ifu_rvalid <= w_ifu_rvalid_nxt;
            r_lsu_rvalid <= w_lsu_rvalid_nxt;
            r_lsu_wready <= w_lsu_wready_nxt;
            r_bus_err    <= w_bus_err_nxt;
        end
    end

    assign o_ifu_rdata   = r_ifu_rdata;
    assign o_ifu_rvalid  = r_ifu_rvalid;
    assign o_lsu_rdata   = r_lsu_rdata;
    assign o_lsu_rvalid  = r_lsu_rvalid;
    assign o_lsu_wready  = r_lsu_wready;
    assign o_mem_arvalid = r_arvalid;
    assign o_mem_araddr  = r_addr;
    assign o_mem_rready  = r_rready;
    assign o_mem_awvalid = r_awvalid;
    assign o_mem_awaddr  = r_addr;
    assign o_mem_wvalid  = r_wvalid;
    assign o_mem_wdata   = r_wdata;
    assign o_mem_wstrb   = r_wstrb;
    assign o_mem_bready  = r_bready;
    assign o_bus_err     = r_bus_err;

endmodule

// File: tb/tb_ysyx_bus_arb.sv
// Self-checking bench for ysyx_bus_arb: table-driven single transactions plus multi-cycle sequences.
module tb_ysyx_bus_arb;
`ifdef YSYX_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk, rst_n;
    logic        ifu_avalid, ifu_rvalid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_avalid, lsu_ren, lsu_wen, lsu_rvalid, lsu_wready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wstrb;
    logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
    logic [31:0] mem_araddr, mem_rdata;
    logic [1:0]  mem_rresp, mem_bresp;
    logic        mem_awvalid, mem_awready, mem_wvalid, mem_wready, mem_bvalid, mem_bready;
    logic [31:0] mem_awaddr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        bus_err;

    ysyx_bus_arb #(.BIT_W(32), .LSU_PRIO(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ifu_avalid(ifu_avalid), .i_ifu_addr(ifu_addr), .o_ifu_rdata(ifu_rdata), .o_ifu_rvalid(ifu_rvalid),
        .i_lsu_avalid(lsu_avalid), .i_lsu_ren(lsu_ren), .i_lsu_wen(lsu_wen), .i_lsu_addr(lsu_addr),
        .i_lsu_wdata(lsu_wdata), .i_lsu_wstrb(lsu_wstrb), .o_lsu_rdata(lsu_rdata),
        .o_lsu_rvalid(lsu_rvalid), .o_lsu_wready(lsu_wready),
        .o_mem_arvalid(mem_arvalid), .o_mem_araddr(mem_araddr), .i_mem_arready(mem_arready),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata), .i_mem_rresp(mem_rresp), .o_mem_rready(mem_rready),
        .o_mem_awvalid(mem_awvalid), .o_mem_awaddr(mem_awaddr), .i_mem_awready(mem_awready),
        .o_mem_wvalid(mem_wvalid), .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb), .i_mem_wready(mem_wready),
        .i_mem_bvalid(mem_bvalid), .i_mem_bresp(mem_bresp), .o_mem_bready(mem_bready),
        .o_bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          lsu;
        bit          ren;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] mdata;
        logic [1:0]  resp;
        logic [2:0]  kind;   // {ifu_rvalid, lsu_rvalid, lsu_wready}
        logic        err;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_ifu, exp_lsu;

    // slave model state
    bit          slv_fixed, slv_hold_r, aw_seen, w_seen;
    logic [31:0] slv_data;
    logic [1:0]  slv_resp;

    // per-cycle snapshot taken on the falling edge
    logic        sn_ifu_rv, sn_lsu_rv, sn_lsu_wr, sn_err, sn_rready, sn_bready;
    logic        sn_arvalid, sn_awvalid, sn_wvalid;
    logic        sn_ar_hs, sn_r_hs, sn_aw_hs, sn_w_hs, sn_b_hs;
    logic [31:0] sn_araddr, sn_awaddr, sn_wdata;
    logic [3:0]  sn_wstrb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: sample at negedge, then update the slave after the rising edge.
    task automatic cycle();
        @(negedge clk);
        sn_ifu_rv = ifu_rvalid;  sn_lsu_rv = lsu_rvalid;  sn_lsu_wr = lsu_wready;  sn_err = bus_err;
        sn_rready = mem_rready;  sn_bready = mem_bready;  sn_arvalid = mem_arvalid;
        sn_awvalid = mem_awvalid; sn_wvalid = mem_wvalid;
        sn_ar_hs = mem_arvalid & mem_arready;  sn_r_hs = mem_rvalid & mem_rready;
        sn_aw_hs = mem_awvalid & mem_awready;  sn_w_hs = mem_wvalid & mem_wready;
        sn_b_hs  = mem_bvalid & mem_bready;
        sn_araddr = mem_araddr; sn_awaddr = mem_awaddr; sn_wdata = mem_wdata; sn_wstrb = mem_wstrb;
        @(posedge clk); #1;
        if (sn_ar_hs) begin
            mem_rvalid = !slv_hold_r;
            mem_rdata  = slv_fixed ? slv_data : ~sn_araddr;
            mem_rresp  = slv_resp;
        end else if (sn_r_hs) begin
            mem_rvalid = 1'b0;
            mem_rresp  = 2'b00;
        end
        if (sn_aw_hs) aw_seen = 1'b1;
        if (sn_w_hs)  w_seen  = 1'b1;
        if (sn_b_hs) begin
            mem_bvalid = 1'b0;
            mem_bresp  = 2'b00;
        end
        if (aw_seen && w_seen) begin
            mem_bvalid = 1'b1;
            mem_bresp  = slv_resp;
            aw_seen = 1'b0;
            w_seen  = 1'b0;
        end
    endtask

    task automatic clear_inputs();
        ifu_avalid = 0; ifu_addr = 0; lsu_avalid = 0; lsu_ren = 0; lsu_wen = 0;
        lsu_addr = 0; lsu_wdata = 0; lsu_wstrb = 0;
        mem_arready = 1; mem_awready = 1; mem_wready = 1;
        mem_rvalid = 0; mem_rdata = 0; mem_rresp = 0; mem_bvalid = 0; mem_bresp = 0;
        slv_fixed = 0; slv_hold_r = 0; aw_seen = 0; w_seen = 0; slv_data = 0; slv_resp = 0;
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk({nm, "_ctl"}, {27'd0, ifu_rvalid, lsu_rvalid, lsu_wready, mem_arvalid, mem_rready},
            32'd0);
        chk({nm, "_wctl"}, {28'd0, mem_awvalid, mem_wvalid, mem_bready, bus_err}, 32'd0);
        chk({nm, "_data"}, ifu_rdata | lsu_rdata | mem_araddr | mem_awaddr | mem_wdata | {28'd0, mem_wstrb},
            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ifu = 0;
        exp_lsu = 0;
        @(posedge clk); #1;
    endtask

    // Drive one request with a zero-wait slave and check latency, routing and error flag.
    task automatic run_txn(input string nm, input vec_t v);
        bit got;
        int lat;
        logic [31:0] seen_addr, seen_wdata;
        logic [3:0]  seen_wstrb;
        got = 0; lat = -1; seen_addr = 32'hx; seen_wdata = 32'hx; seen_wstrb = 4'hx;
        slv_fixed = 1; slv_data = v.mdata; slv_resp = v.resp;
        if (v.lsu) begin
            lsu_avalid = 1; lsu_ren = v.ren; lsu_wen = v.wen;
            lsu_addr = v.addr; lsu_wdata = v.wdata; lsu_wstrb = v.wstrb;
        end else begin
            ifu_avalid = 1; ifu_addr = v.addr;
        end
        for (int k = 0; k < 20 && !got; k++) begin
            cycle();
            if (sn_ar_hs) seen_addr = sn_araddr;
            if (sn_aw_hs) seen_addr = sn_awaddr;
            if (sn_w_hs) begin
                seen_wdata = sn_wdata;
                seen_wstrb = sn_wstrb;
            end
            if (sn_ifu_rv | sn_lsu_rv | sn_lsu_wr) begin
                got = 1;
                lat = k;
                ifu_avalid = 0;
                lsu_avalid = 0;
            end
        end
        chk({nm, "_done"}, 32'(got), 32'd1);
        if (got) begin
            if (v.kind == 3'b100) exp_ifu = v.mdata;
            if (v.kind == 3'b010) exp_lsu = v.mdata;
            chk({nm, "_kind"}, {29'd0, sn_ifu_rv, sn_lsu_rv, sn_lsu_wr}, {29'd0, v.kind});
            chk({nm, "_lat"}, 32'(lat), 32'd3);
            chk({nm, "_err"}, 32'(sn_err), 32'(v.err));
            chk({nm, "_addr"}, seen_addr, v.addr);
            chk({nm, "_ifu_rdata"}, ifu_rdata, exp_ifu);
            chk({nm, "_lsu_rdata"}, lsu_rdata, exp_lsu);
            if (v.kind == 3'b001) begin
                chk({nm, "_wdata"}, seen_wdata, v.wdata);
                chk({nm, "_wstrb"}, {28'd0, seen_wstrb}, {28'd0, v.wstrb});
            end
            cycle();
            chk({nm, "_one_pulse"}, {28'd0, sn_ifu_rv, sn_lsu_rv, sn_lsu_wr, sn_err}, 32'd0);
        end
    endtask

    vec_t vecs[8];

    initial begin
        int ifu_ar_k, lsu_ar_k, ifu_pk, lsu_pk, n_pulse, n_grant, n_wr;
        bit order[6];
        logic [31:0] a_ifu, a_lsu;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0,         4'h0,    32'h0000_0413, 2'b00, 3'b100, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h0,         4'h0,    32'h1234_5678, 2'b00, 3'b010, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF,    32'h0,         2'b00, 3'b001, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h8000_0020, 32'h0,         4'h0,    32'hCAFE_F00D, 2'b10, 3'b010, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h8000_0030, 32'h1111_2222, 4'h3,    32'h0BAD_CAFE, 2'b00, 3'b010, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h8000_1004, 32'h0000_00AB, 4'h1,    32'h0,         2'b01, 3'b001, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h8000_1008, 32'h5555_AAAA, 4'b1100, 32'h0,         2'b11, 3'b001, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h8000_0004, 32'h0,         4'h0,    32'h0010_0093, 2'b00, 3'b100, 1'b0};

        rst_n = 1'b0;
        clear_inputs();
        exp_ifu = 0;
        exp_lsu = 0;
        do_reset("rst0");

        for (int i = 0; i < 8; i++) run_txn($sformatf("v%0d", i), vecs[i]);

        // Store with awready two cycles ahead of wready.
        mem_wready = 0;
        slv_resp = 0;
        lsu_avalid = 1; lsu_ren = 0; lsu_wen = 1;
        lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
        n_wr = 0;
        for (int k = 0; k < 7; k++) begin
            cycle();
            n_wr += int'(sn_lsu_wr);
            case (k)
                1: begin
                    chk("sa_aw_wv_c1", {30'd0, sn_awvalid, sn_wvalid}, 32'd3);
                    chk("sa_awaddr", sn_awaddr, 32'h8000_1000);
                    chk("sa_wdata", sn_wdata, 32'hDEAD_BEEF);
                end
                2: begin
                    chk("sa_aw_drop_c2", {30'd0, sn_awvalid, sn_wvalid}, 32'd1);
                    mem_wready = 1;
                end
                3: chk("sa_w_hold_c3", {30'd0, sn_awvalid, sn_wvalid}, 32'd1);
                4: chk("sa_bready_c4", {29'd0, sn_wvalid, sn_bready, sn_lsu_wr}, 32'd2);
                5: begin
                    chk("sa_wready_c5", {30'd0, sn_lsu_wr, sn_err}, 32'd2);
                    lsu_avalid = 0;
                end
                default: ;
            endcase
        end
        chk("sa_wready_count", 32'(n_wr), 32'd1);

        // Simultaneous single reads from both masters.
        do_reset("rst1");
        a_ifu = 32'h8000_0100;
        a_lsu = 32'h8000_2000;
        ifu_addr = a_ifu; lsu_addr = a_lsu; lsu_ren = 1; lsu_wen = 0;
        ifu_avalid = 1; lsu_avalid = 1;
        ifu_ar_k = -1; lsu_ar_k = -1; ifu_pk = -1; lsu_pk = -1;
        for (int k = 0; k < 30 && (ifu_pk < 0 || lsu_pk < 0); k++) begin
            cycle();
            if (sn_ar_hs && sn_araddr == a_lsu && lsu_ar_k < 0) lsu_ar_k = k;
            if (sn_ar_hs && sn_araddr == a_ifu && ifu_ar_k < 0) ifu_ar_k = k;
            if (sn_ifu_rv) begin ifu_pk = k; ifu_avalid = 0; end
            if (sn_lsu_rv) begin lsu_pk = k; lsu_avalid = 0; end
        end
        chk("sb_ifu_ar_cycle", 32'(ifu_ar_k), RR ? 32'd1 : 32'd5);
        chk("sb_lsu_ar_cycle", 32'(lsu_ar_k), RR ? 32'd5 : 32'd1);
        chk("sb_ifu_pulse_cycle", 32'(ifu_pk), RR ? 32'd3 : 32'd7);
        chk("sb_lsu_pulse_cycle", 32'(lsu_pk), RR ? 32'd7 : 32'd3);
        chk("sb_ifu_rdata", ifu_rdata, ~a_ifu);
        chk("sb_lsu_rdata", lsu_rdata, ~a_lsu);

        // Continuous contention for six transactions.
        ifu_avalid = 1; lsu_avalid = 1;
        n_pulse = 0; n_grant = 0;
        for (int k = 0; k < 80 && n_pulse < 6; k++) begin
            cycle();
            if (sn_ar_hs && n_grant < 6) begin
                order[n_grant] = (sn_araddr == a_lsu);
                n_grant++;
            end
            if (sn_ifu_rv) begin
                n_pulse++;
                chk("sc_ifu_route", ifu_rdata, ~a_ifu);
            end
            if (sn_lsu_rv) begin
                n_pulse++;
                chk("sc_lsu_route", lsu_rdata, ~a_lsu);
            end
        end
        ifu_avalid = 0; lsu_avalid = 0;
        chk("sc_pulses", 32'(n_pulse), 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("sc_order%0d", i), 32'(order[i]), RR ? 32'(i % 2) : 32'd1);
        repeat (3) cycle();

        // Reset asserted while waiting in RD_DATA.
        ifu_addr = 32'h8000_0200;
        ifu_avalid = 1;
        slv_hold_r = 1;
        sn_rready = 0;
        for (int k = 0; k < 10 && !sn_rready; k++) cycle();
        chk("sr_in_rd_data", 32'(sn_rready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("sr_async_ctl", {24'd0, ifu_rvalid, lsu_rvalid, lsu_wready, mem_arvalid, mem_rready,
            mem_awvalid, mem_wvalid, mem_bready}, 32'd0);
        chk("sr_async_data", ifu_rdata | lsu_rdata | mem_araddr | {31'd0, bus_err}, 32'd0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        exp_ifu = 0;
        exp_lsu = 0;
        @(posedge clk); #1;
        run_txn("sr_fresh", vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
